// File: rtl/axi_pkg.sv
// -----------------------------------------------------------------------------
// axi_pkg
// Shared AXI4-Lite definitions used by the load/store master.
//   resp_t  : AXI response encoding (OKAY, EXOKAY, SLVERR, DECERR)
//   state_t : control states of axi_lite_mem_master
// -----------------------------------------------------------------------------
package axi_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_WRESP,
        ST_READ,
        ST_RDATA,
        ST_ERR
    } state_t;

endpackage

// File: rtl/axi_lite_mem_master.sv
// -----------------------------------------------------------------------------
// axi_lite_mem_master
// Converts a simple CPU load/store request port into single AXI4-Lite
// transactions, one outstanding at a time. Misaligned or out-of-window
// requests are answered locally with an error and never reach the bus.
// An optional watchdog aborts a transaction the slave does not finish.
//
// Ports
//   aclk, aresetn                      clock, asynchronous active-low reset
//   req_valid/req_ready                request handshake
//   req_we, req_addr, req_wdata, req_wstrb   request payload (1 = store)
//   rsp_valid                          one-cycle completion pulse
//   rsp_rdata, rsp_err                 load data (0 otherwise), error flag
//   m_aw*/m_w*/m_b*                    AXI-Lite write address, data, response
//   m_ar*/m_r*                         AXI-Lite read address, data
// All outputs are registered.
// -----------------------------------------------------------------------------
module axi_lite_mem_master
    import axi_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int                SIZE_BYTES = 4096,
    parameter int                TIMEOUT    = 0
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wvalid,
    input  logic                m_wready,
    input  logic [1:0]          m_bresp,
    input  logic                m_bvalid,
    output logic                m_bready,
    output logic [ADDR_W-1:0]   m_araddr,
    output logic                m_arvalid,
    input  logic                m_arready,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    input  logic                m_rvalid,
    output logic                m_rready
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    // Window bounds carry one extra bit so BASE_ADDR+SIZE_BYTES cannot wrap.
    localparam logic [ADDR_W:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [ADDR_W:0] WIN_HI = {1'b0, BASE_ADDR} + (ADDR_W+1)'(SIZE_BYTES);

    state_t              state_reg, state_next;
    logic                req_ready_reg, req_ready_next;
    logic [ADDR_W-1:0]   m_awaddr_reg, m_awaddr_next;
    logic                m_awvalid_reg, m_awvalid_next;
    logic [DATA_W-1:0]   m_wdata_reg, m_wdata_next;
    logic [DATA_W/8-1:0] m_wstrb_reg, m_wstrb_next;
    logic                m_wvalid_reg, m_wvalid_next;
    logic                m_bready_reg, m_bready_next;
    logic [ADDR_W-1:0]   m_araddr_reg, m_araddr_next;
    logic                m_arvalid_reg, m_arvalid_next;
    logic                m_rready_reg, m_rready_next;
    logic                rsp_valid_reg, rsp_valid_next;
    logic                rsp_err_reg, rsp_err_next;
    logic [DATA_W-1:0]   rsp_rdata_reg, rsp_rdata_next;
    logic [CNT_W-1:0]    wd_cnt_reg, wd_cnt_next;

    logic req_bad;
    logic aw_fin;
    logic w_fin;
    logic wd_expire;

    assign req_bad = (req_addr[1:0] != 2'b00)
                   || ({1'b0, req_addr} <  WIN_LO)
                   || ({1'b0, req_addr} >= WIN_HI);

    // A channel is finished once it has handshaken (valid already dropped)
    // or is handshaking this cycle.
    assign aw_fin = !m_awvalid_reg || m_awready;
    assign w_fin  = !m_wvalid_reg  || m_wready;

    // The abort is registered, so it is decided one cycle early: the error
    // pulse then lands TIMEOUT cycles after the accept.
    assign wd_expire = (TIMEOUT > 0) && (state_reg != ST_IDLE) && (state_reg != ST_ERR)
                     && (int'(wd_cnt_reg) + 2 >= TIMEOUT);

    always_comb begin
        state_next     = state_reg;
        req_ready_next = req_ready_reg;
        m_awaddr_next  = m_awaddr_reg;
        m_awvalid_next = m_awvalid_reg;
        m_wdata_next   = m_wdata_reg;
        m_wstrb_next   = m_wstrb_reg;
        m_wvalid_next  = m_wvalid_reg;
        m_bready_next  = m_bready_reg;
        m_araddr_next  = m_araddr_reg;
        m_arvalid_next = m_arvalid_reg;
        m_rready_next  = m_rready_reg;
        rsp_valid_next = 1'b0;
        rsp_err_next   = 1'b0;
        rsp_rdata_next = '0;
        wd_cnt_next    = wd_cnt_reg;

        if (TIMEOUT > 0 && state_reg != ST_IDLE) begin
            wd_cnt_next = wd_cnt_reg + CNT_W'(1);
        end

        case (state_reg)
            ST_IDLE: begin
                req_ready_next = 1'b1;
                if (req_valid && req_ready_reg) begin
                    req_ready_next = 1'b0;
                    wd_cnt_next    = '0;
                    if (req_bad) begin
                        // Error response is registered now so it shows while in ERR.
                        state_next     = ST_ERR;
                        rsp_valid_next = 1'b1;
                        rsp_err_next   = 1'b1;
                    end else if (req_we) begin
                        state_next     = ST_WRITE;
                        m_awaddr_next  = req_addr;
                        m_wdata_next   = req_wdata;
                        m_wstrb_next   = req_wstrb;
                        m_awvalid_next = 1'b1;
                        m_wvalid_next  = 1'b1;
                    end else begin
                        // rready rides with arvalid: the RAM slave ties arready to rready.
                        state_next     = ST_READ;
                        m_araddr_next  = req_addr;
                        m_arvalid_next = 1'b1;
                        m_rready_next  = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                m_awvalid_next = m_awvalid_reg && !m_awready;
                m_wvalid_next  = m_wvalid_reg  && !m_wready;
                if (aw_fin && w_fin) begin
                    state_next    = ST_WRESP;
                    m_bready_next = 1'b1;
                end
            end
            ST_WRESP: begin
                if (m_bvalid) begin
                    state_next     = ST_IDLE;
                    req_ready_next = 1'b1;
                    m_bready_next  = 1'b0;
                    rsp_valid_next = 1'b1;
                    rsp_err_next   = (resp_t'(m_bresp) != OKAY);
                end
            end
            ST_READ: begin
                if (m_arready) begin
                    state_next     = ST_RDATA;
                    m_arvalid_next = 1'b0;
                end
            end
            ST_RDATA: begin
                if (m_rvalid) begin
                    state_next     = ST_IDLE;
                    req_ready_next = 1'b1;
                    m_rready_next  = 1'b0;
                    rsp_valid_next = 1'b1;
                    rsp_err_next   = (resp_t'(m_rresp) != OKAY);
                    rsp_rdata_next = (resp_t'(m_rresp) == OKAY) ? m_rdata : '0;
                end
            end
            ST_ERR: begin
                state_next     = ST_IDLE;
                req_ready_next = 1'b1;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (wd_expire) begin
            state_next     = ST_IDLE;
            req_ready_next = 1'b1;
            m_awvalid_next = 1'b0;
            m_wvalid_next  = 1'b0;
            m_bready_next  = 1'b0;
            m_arvalid_next = 1'b0;
            m_rready_next  = 1'b0;
            rsp_valid_next = 1'b1;
            rsp_err_next   = 1'b1;
            rsp_rdata_next = '0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_reg     <= ST_IDLE;
            req_ready_reg <= 1'b0;
            m_awaddr_reg  <= '0;
            m_awvalid_reg <= 1'b0;
            m_wdata_reg   <= '0;
            m_wstrb_reg   <= '0;
            m_wvalid_reg  <= 1'b0;
            m_bready_reg  <= 1'b0;
            m_araddr_reg  <= '0;
            m_arvalid_reg <= 1'b0;
            m_rready_reg  <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= '0;
            wd_cnt_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            req_ready_reg <= req_ready_next;
            m_awaddr_reg  <= m_awaddr_next;
            m_awvalid_reg <= m_awvalid_next;
            m_wdata_reg   <= m_wdata_next;
            m_wstrb_reg   <= m_wstrb_next;
            m_wvalid_reg  <= m_wvalid_next;
            m_bready_reg  <= m_bready_next;
            m_araddr_reg  <= m_araddr_next;
            m_arvalid_reg <= m_arvalid_next;
            m_rready_reg  <= m_rready_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_err_reg   <= rsp_err_next;
            rsp_rdata_reg <= rsp_rdata_next;
            wd_cnt_reg    <= wd_cnt_next;
        end
    end

    assign req_ready = req_ready_reg;
    assign m_awaddr  = m_awaddr_reg;
    assign m_awvalid = m_awvalid_reg;
    assign m_wdata   = m_wdata_reg;
    assign m_wstrb   = m_wstrb_reg;
    assign m_wvalid  = m_wvalid_reg;
    assign m_bready  = m_bready_reg;
    assign m_araddr  = m_araddr_reg;
    assign m_arvalid = m_arvalid_reg;
    assign m_rready  = m_rready_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_err   = rsp_err_reg;
    assign rsp_rdata = rsp_rdata_reg;

endmodule

// File: tb/tb_axi_lite_mem_master.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_mem_master
// Drives axi_lite_mem_master (window 0..4095, watchdog 8 cycles) against a
// behavioural AXI-Lite RAM slave and predicts every response from a word
// memory model plus the request rules (alignment, window, latency).
// -----------------------------------------------------------------------------
module tb_axi_lite_mem_master;

    localparam int TO = 8;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] m_awaddr;
    logic        m_awvalid;
    logic        m_awready = 1'b0;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wvalid;
    logic        m_wready = 1'b0;
    logic [1:0]  m_bresp = 2'b00;
    logic        m_bvalid = 1'b0;
    logic        m_bready;
    logic [31:0] m_araddr;
    logic        m_arvalid;
    logic        m_arready = 1'b0;
    logic [31:0] m_rdata = '0;
    logic [1:0]  m_rresp = 2'b00;
    logic        m_rvalid = 1'b0;
    logic        m_rready;

    int total = 0;
    int bad   = 0;

    always #5 aclk = ~aclk;

    axi_lite_mem_master #(
        .ADDR_W(32), .DATA_W(32), .BASE_ADDR(32'h0), .SIZE_BYTES(4096), .TIMEOUT(TO)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    // ---------------- behavioural RAM slave (decides at the falling edge) ----
    logic [31:0] smem [int];
    int          aw_stall = 0;
    bit          silent = 0;
    bit          berr = 0;
    int          w_beats = 0;
    bit          aw_fire = 0, w_fire = 0, ar_fire = 0, b_fire = 0, r_fire = 0;
    bit          aw_have = 0, w_have = 0, ar_have = 0;
    logic [31:0] aw_a = '0, ar_a = '0, w_d = '0;
    logic [3:0]  w_s = '0;

    always @(negedge aclk) begin
        if (!aresetn) begin
            m_awready = 0; m_wready = 0; m_arready = 0;
            m_bvalid = 0; m_bresp = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
            aw_fire = 0; w_fire = 0; ar_fire = 0; b_fire = 0; r_fire = 0;
            aw_have = 0; w_have = 0; ar_have = 0;
        end else begin
            if (b_fire) m_bvalid = 0;
            if (r_fire) begin m_rvalid = 0; m_rdata = 0; end
            if (aw_fire) aw_have = 1;
            if (w_fire)  w_have = 1;
            if (ar_fire) ar_have = 1;
            if (aw_have && w_have && !m_bvalid) begin
                if (!berr) begin
                    logic [31:0] old;
                    old = smem.exists(int'(aw_a >> 2)) ? smem[int'(aw_a >> 2)] : 32'h0;
                    for (int b = 0; b < 4; b++) if (w_s[b]) old[8*b +: 8] = w_d[8*b +: 8];
                    smem[int'(aw_a >> 2)] = old;
                end
                m_bresp  = berr ? 2'b10 : 2'b00;
                m_bvalid = 1;
                aw_have = 0; w_have = 0;
            end
            if (ar_have && !m_rvalid) begin
                m_rdata  = smem.exists(int'(ar_a >> 2)) ? smem[int'(ar_a >> 2)] : 32'h0;
                m_rresp  = 2'b00;
                m_rvalid = 1;
                ar_have  = 0;
            end
            if (m_awvalid && !aw_have && !silent) begin
                if (aw_stall > 0) begin m_awready = 0; aw_stall--; end
                else m_awready = 1;
            end else m_awready = 0;
            m_wready  = !silent && !w_have;
            m_arready = silent ? 1'b0 : m_rready;
            aw_fire = m_awvalid && m_awready;
            w_fire  = m_wvalid && m_wready;
            ar_fire = m_arvalid && m_arready;
            b_fire  = m_bvalid && m_bready;
            r_fire  = m_rvalid && m_rready;
            if (aw_fire) aw_a = m_awaddr;
            if (w_fire) begin w_d = m_wdata; w_s = m_wstrb; w_beats++; end
            if (ar_fire) ar_a = m_araddr;
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [int];

    function automatic bit ref_local_err(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'd4096);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(int'(a / 4)) ? ref_mem[int'(a / 4)] : 32'h0;
    endfunction

    task automatic ref_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w;
        w = ref_rd(a);
        for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
        ref_mem[int'(a / 4)] = w;
    endtask

    // ---------------- driver ----------------
    task automatic tick;
        @(negedge aclk);
        #1;
    endtask

    // Issues one request, returns cycles from accept to rsp_valid (-1 if none).
    task automatic run_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, output int lat, output logic err,
                           output logic [31:0] rdata, output logic bus_seen,
                           output logic [31:0] first_addr);
        int guard;
        lat = -1; err = 0; rdata = 0; bus_seen = 0; first_addr = 0;
        guard = 0;
        while (!req_ready && guard < 50) begin tick(); guard++; end
        req_valid = 1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
        tick();
        req_valid = 0;
        for (int c = 1; c <= 50; c++) begin
            if (m_awvalid || m_wvalid || m_arvalid) bus_seen = 1;
            if (c == 1) first_addr = we ? m_awaddr : m_araddr;
            if (rsp_valid) begin lat = c; err = rsp_err; rdata = rsp_rdata; break; end
            tick();
        end
        $display("txn we=%0b addr=0x%08h wdata=0x%08h strb=%b -> lat=%0d err=%0b rdata=0x%08h",
                 we, addr, wdata, wstrb, lat, err, rdata);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        aresetn = 0;
        tick(); tick();
        total++;
        if ({req_ready, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, rsp_valid, rsp_err} !== 8'h00) begin
            bad++; $display("FAIL reset_ctrl got=%b want=00000000",
                {req_ready, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, rsp_valid, rsp_err});
        end
        total++;
        if ({m_awaddr, m_araddr, m_wdata, m_wstrb, rsp_rdata} !== '0) begin
            bad++; $display("FAIL reset_payload got aw=%h ar=%h wd=%h ws=%h rd=%h want all 0",
                m_awaddr, m_araddr, m_wdata, m_wstrb, rsp_rdata);
        end
        aresetn = 1;
        tick();
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", req_ready); end
    endtask

    task automatic test_write_read;
        int lat; logic err, seen; logic [31:0] rd, fa;
        run_req(1, 32'h10, 32'hDEADBEEF, 4'hF, lat, err, rd, seen, fa);
        ref_wr(32'h10, 32'hDEADBEEF, 4'hF);
        total++; if (lat !== 3) begin bad++; $display("FAIL wr_lat got=%0d want=3", lat); end
        total++; if ({err, rd} !== 33'h0) begin bad++; $display("FAIL wr_rsp got err=%b rd=%h want 0/0", err, rd); end
        total++; if (fa !== 32'h10) begin bad++; $display("FAIL wr_awaddr got=%h want=00000010", fa); end
        tick();
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL wr_pulse got=%b want=0", rsp_valid); end
        run_req(0, 32'h10, 32'h0, 4'h0, lat, err, rd, seen, fa);
        total++; if (lat !== 3) begin bad++; $display("FAIL rd_lat got=%0d want=3", lat); end
        total++; if (rd !== ref_rd(32'h10) || err !== 1'b0) begin
            bad++; $display("FAIL rd_data got=%h err=%b want=%h err=0", rd, err, ref_rd(32'h10)); end
        total++; if (fa !== 32'h10) begin bad++; $display("FAIL rd_araddr got=%h want=00000010", fa); end
    endtask

    task automatic test_partial_strobe;
        int lat; logic err, seen; logic [31:0] rd, fa;
        run_req(1, 32'h10, 32'h11223344, 4'b0011, lat, err, rd, seen, fa);
        ref_wr(32'h10, 32'h11223344, 4'b0011);
        run_req(0, 32'h10, 32'h0, 4'h0, lat, err, rd, seen, fa);
        total++; if (rd !== 32'hDEAD3344) begin bad++; $display("FAIL strobe_data got=%h want=dead3344", rd); end
    endtask

    task automatic test_back_to_back;
        int lat; logic err, seen; logic [31:0] rd, fa;
        run_req(0, 32'h10, 32'h0, 4'h0, lat, err, rd, seen, fa);
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b want=1", req_ready); end
        run_req(1, 32'h14, 32'hA5A5_0F0F, 4'hF, lat, err, rd, seen, fa);
        ref_wr(32'h14, 32'hA5A5_0F0F, 4'hF);
        total++; if (lat !== 3) begin bad++; $display("FAIL b2b_lat got=%0d want=3", lat); end
    endtask

    task automatic test_stalled_aw;
        int guard, pulses, lat, w0; logic err;
        int lat2; logic err2, seen; logic [31:0] rd, fa;
        guard = 0;
        while (!req_ready && guard < 50) begin tick(); guard++; end
        aw_stall = 3; w0 = w_beats; pulses = 0; lat = -1; err = 0;
        req_valid = 1; req_we = 1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_wstrb = 4'hF;
        tick();
        req_valid = 0;
        total++; if ({m_awvalid, m_wvalid} !== 2'b11) begin bad++; $display("FAIL stall_c1 got aw/w=%b want=11", {m_awvalid, m_wvalid}); end
        tick();
        total++; if ({m_awvalid, m_wvalid} !== 2'b10) begin bad++; $display("FAIL stall_c2 got aw/w=%b want=10", {m_awvalid, m_wvalid}); end
        tick(); tick();
        total++; if ({m_awvalid, m_wvalid} !== 2'b10) begin bad++; $display("FAIL stall_c4 got aw/w=%b want=10", {m_awvalid, m_wvalid}); end
        for (int c = 5; c <= 16; c++) begin
            tick();
            if (rsp_valid) begin pulses++; if (lat < 0) begin lat = c; err = rsp_err; end end
        end
        ref_wr(32'h20, 32'hCAFEF00D, 4'hF);
        $display("txn we=1 addr=0x00000020 stalled-aw -> lat=%0d err=%0b pulses=%0d", lat, err, pulses);
        total++; if (lat !== 6 || err !== 1'b0) begin bad++; $display("FAIL stall_rsp got lat=%0d err=%b want lat=6 err=0", lat, err); end
        total++; if (pulses !== 1) begin bad++; $display("FAIL stall_pulses got=%0d want=1", pulses); end
        total++; if (w_beats - w0 !== 1) begin bad++; $display("FAIL stall_wbeats got=%0d want=1", w_beats - w0); end
        run_req(0, 32'h20, 32'h0, 4'h0, lat2, err2, rd, seen, fa);
        total++; if (rd !== ref_rd(32'h20)) begin bad++; $display("FAIL stall_readback got=%h want=%h", rd, ref_rd(32'h20)); end
    endtask

    task automatic test_local_errors;
        int lat; logic err, seen; logic [31:0] rd, fa;
        run_req(0, 32'h1000, 32'h0, 4'h0, lat, err, rd, seen, fa);
        total++; if (lat !== 1 || err !== 1'b1 || rd !== 32'h0) begin
            bad++; $display("FAIL oow_rsp got lat=%0d err=%b rd=%h want lat=1 err=1 rd=0", lat, err, rd); end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL oow_bus got=%b want=0", seen); end
        run_req(0, 32'h2, 32'h0, 4'h0, lat, err, rd, seen, fa);
        total++; if (lat !== 1 || err !== 1'b1 || rd !== 32'h0) begin
            bad++; $display("FAIL misalign_rsp got lat=%0d err=%b rd=%h want lat=1 err=1 rd=0", lat, err, rd); end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL misalign_bus got=%b want=0", seen); end
        run_req(1, 32'hFFC, 32'h0BAD_F00D, 4'hF, lat, err, rd, seen, fa);
        ref_wr(32'hFFC, 32'h0BAD_F00D, 4'hF);
        run_req(0, 32'hFFC, 32'h0, 4'h0, lat, err, rd, seen, fa);
        total++; if (lat !== 3 || err !== 1'b0 || rd !== ref_rd(32'hFFC)) begin
            bad++; $display("FAIL edge_rsp got lat=%0d err=%b rd=%h want lat=3 err=0 rd=%h", lat, err, rd, ref_rd(32'hFFC)); end
    endtask

    task automatic test_slave_error;
        int lat; logic err, seen; logic [31:0] rd, fa;
        berr = 1;
        run_req(1, 32'h30, 32'h55AA55AA, 4'hF, lat, err, rd, seen, fa);
        berr = 0;
        total++; if (lat !== 3 || err !== 1'b1 || rd !== 32'h0) begin
            bad++; $display("FAIL slverr_rsp got lat=%0d err=%b rd=%h want lat=3 err=1 rd=0", lat, err, rd); end
    endtask

    task automatic test_timeout;
        int lat; logic err, seen; logic [31:0] rd, fa;
        silent = 1;
        run_req(0, 32'h40, 32'h0, 4'h0, lat, err, rd, seen, fa);
        total++; if (lat !== TO || err !== 1'b1 || rd !== 32'h0) begin
            bad++; $display("FAIL timeout_rsp got lat=%0d err=%b rd=%h want lat=%0d err=1 rd=0", lat, err, rd, TO); end
        tick();
        total++; if ({req_ready, m_arvalid, m_rready, rsp_valid} !== 4'b1000) begin
            bad++; $display("FAIL timeout_idle got ready/arv/rr/rsp=%b want=1000", {req_ready, m_arvalid, m_rready, rsp_valid}); end
        silent = 0;
        run_req(0, 32'h10, 32'h0, 4'h0, lat, err, rd, seen, fa);
        total++; if (lat !== 3 || rd !== ref_rd(32'h10)) begin
            bad++; $display("FAIL timeout_recover got lat=%0d rd=%h want lat=3 rd=%h", lat, rd, ref_rd(32'h10)); end
    endtask

    task automatic test_reset_midflight;
        int guard, lat; logic err, seen; logic [31:0] rd, fa;
        guard = 0;
        while (!req_ready && guard < 50) begin tick(); guard++; end
        req_valid = 1; req_we = 0; req_addr = 32'h10;
        tick();
        req_valid = 0;
        tick();
        total++; if (m_rready !== 1'b1) begin bad++; $display("FAIL midrst_pre got rready=%b want=1", m_rready); end
        aresetn = 0;
        #1;
        total++; if ({req_ready, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, rsp_valid, rsp_err} !== 8'h00
                     || m_araddr !== 32'h0 || rsp_rdata !== 32'h0) begin
            bad++; $display("FAIL midrst_clear got ctrl=%b araddr=%h rd=%h want all 0",
                {req_ready, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, rsp_valid, rsp_err}, m_araddr, rsp_rdata);
        end
        tick(); tick();
        aresetn = 1;
        tick();
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL midrst_norsp got=%b want=0", rsp_valid); end
        run_req(0, 32'h10, 32'h0, 4'h0, lat, err, rd, seen, fa);
        total++; if (lat !== 3 || err !== 1'b0 || rd !== ref_rd(32'h10)) begin
            bad++; $display("FAIL midrst_after got lat=%0d err=%b rd=%h want lat=3 err=0 rd=%h", lat, err, rd, ref_rd(32'h10)); end
    endtask

    task automatic test_random;
        int lat, sel, exp_lat; logic err, seen, we, exp_err; logic [31:0] rd, fa, a, d, exp_rd; logic [3:0] s;
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 9);
            we  = 1'($urandom_range(0, 1));
            d   = $urandom;
            s   = 4'($urandom_range(0, 15));
            if (sel == 0)      a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
            else if (sel == 1) a = ($urandom_range(0, 1) == 0) ? 32'(32'h1000 + $urandom_range(0, 255) * 4) : 32'hFFFF_FFFC;
            else if (sel == 9) a = 32'hFFC;
            else               a = 32'($urandom_range(0, 15) * 4);
            exp_err = ref_local_err(a);
            exp_lat = exp_err ? 1 : 3;
            exp_rd  = (exp_err || we) ? 32'h0 : ref_rd(a);
            run_req(we, a, d, s, lat, err, rd, seen, fa);
            if (!exp_err && we) ref_wr(a, d, s);
            total++; if (lat !== exp_lat || err !== exp_err) begin
                bad++; $display("FAIL rand_rsp[%0d] addr=%h got lat=%0d err=%b want lat=%0d err=%b", i, a, lat, err, exp_lat, exp_err); end
            total++; if (rd !== exp_rd) begin
                bad++; $display("FAIL rand_data[%0d] addr=%h got=%h want=%h", i, a, rd, exp_rd); end
            total++; if (seen !== !exp_err) begin
                bad++; $display("FAIL rand_bus[%0d] addr=%h got=%b want=%b", i, a, seen, !exp_err); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit got=expired want=finish");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_write_read();
        test_partial_strobe();
        test_back_to_back();
        test_stalled_aw();
        test_local_errors();
        test_slave_error();
        test_timeout();
        test_reset_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
